// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath-side signal bundle for the pipeline hazard sequencer
interface hazard_ctrl_if;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  rs1_e;
   logic [4:0]  rs2_e;
   logic [4:0]  rd_e;
   logic [1:0]  result_src_e;
   logic        pc_src_e;
   logic [4:0]  rd_m;
   logic [4:0]  rd_w;
   logic        regwrite_m;
   logic        regwrite_w;
   logic        dmem_req_m;
   logic        dmem_ready_m;
   logic        stall_f;
   logic        stall_d;
   logic        stall_e;
   logic        stall_m;
   logic        flush_d;
   logic        flush_e;
   logic        flush_w;
   logic [1:0]  forward_a_e;
   logic [1:0]  forward_b_e;
   logic        mem_timeout;
   logic [31:0] ldstall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] memwait_cnt;

   // Datapath side: supplies stage indices and control bits, consumes pipeline controls
   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
             rd_m, rd_w, regwrite_m, regwrite_w, dmem_req_m, dmem_ready_m,
      input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
             forward_a_e, forward_b_e, mem_timeout,
             ldstall_cnt, flush_cnt, memwait_cnt
   );

   // Sequencer side
   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
             rd_m, rd_w, regwrite_m, regwrite_w, dmem_req_m, dmem_ready_m,
      output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
             forward_a_e, forward_b_e, mem_timeout,
             ldstall_cnt, flush_cnt, memwait_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I stall/flush/forwarding sequencer with memory-wait watchdog
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input logic          clk,
   input logic          clear,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      TIMEOUT  = 2'b10
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
   logic               timeout_q;

   logic               mwait;
   logic               redirect;
   logic               load_use;
   logic               stall_f, stall_d, stall_e, stall_m;
   logic               flush_d, flush_e, flush_w;
   logic [1:0]         fwd_a, fwd_b;

   // A pending data-memory access freezes the whole pipeline, including E's redirect
   assign mwait    = hz.dmem_req_m && !hz.dmem_ready_m;
   assign redirect = !mwait && hz.pc_src_e;
   // A wrong-path instruction in D never needs a load-use stall, hence !pc_src_e
   assign load_use = !mwait && !hz.pc_src_e && (hz.result_src_e == 2'b01) &&
                     (hz.rd_e != 5'd0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

   // E-stage operand forwarding; the younger M result wins over W
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!clear) begin
         if (hz.regwrite_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs1_e))
            fwd_a = 2'b10;
         else if (hz.regwrite_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_e))
            fwd_a = 2'b01;
         if (hz.regwrite_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs2_e))
            fwd_b = 2'b10;
         else if (hz.regwrite_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_e))
            fwd_b = 2'b01;
      end
   end

   // Next-state and wait-cycle counting for the memory-wait watchdog
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      case (state)
         RUN: begin
            if (mwait) begin
               state_nx    = MEM_WAIT;
               wait_cnt_nx = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!mwait) begin
               state_nx    = RUN;
               wait_cnt_nx = '0;
            end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
               state_nx    = TIMEOUT;
            end else begin
               wait_cnt_nx = wait_cnt + CNT_W'(1);
            end
         end
         TIMEOUT: begin
            state_nx = TIMEOUT;
         end
         default: begin
            state_nx    = RUN;
            wait_cnt_nx = '0;
         end
      endcase
   end

   // Stall/flush decode: reset bubbles, timeout freeze, then mwait > redirect > load-use
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (clear) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (state == TIMEOUT) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (mwait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (redirect) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_use) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // State register, wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nx;
         wait_cnt  <= wait_cnt_nx;
         timeout_q <= timeout_q || (state_nx == TIMEOUT);
      end
   end

   assign hz.stall_f     = stall_f;
   assign hz.stall_d     = stall_d;
   assign hz.stall_e     = stall_e;
   assign hz.stall_m     = stall_m;
   assign hz.flush_d     = flush_d;
   assign hz.flush_e     = flush_e;
   assign hz.flush_w     = flush_w;
   assign hz.forward_a_e = fwd_a;
   assign hz.forward_b_e = fwd_b;
   assign hz.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ldstall_q, flush_q, memwait_q;

   // Event counters: load-use is the only stall_d without stall_m; outside
   // reset, flush_d comes only from a redirect
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         ldstall_q <= 32'd0;
         flush_q   <= 32'd0;
         memwait_q <= 32'd0;
      end else begin
         if (stall_d && !stall_m) ldstall_q <= ldstall_q + 32'd1;
         if (flush_d)             flush_q   <= flush_q + 32'd1;
         if (stall_m)             memwait_q <= memwait_q + 32'd1;
      end
   end

   assign hz.ldstall_cnt = ldstall_q;
   assign hz.flush_cnt   = flush_q;
   assign hz.memwait_cnt = memwait_q;
`else
   assign hz.ldstall_cnt = 32'd0;
   assign hz.flush_cnt   = 32'd0;
   assign hz.memwait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  stall;   // {f,d,e,m}
      logic [2:0]  flush;   // {d,e,w}
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        tmo;
      logic        chk_cnt;
      logic [31:0] c_ld;
      logic [31:0] c_fl;
      logic [31:0] c_mw;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_vec  = 0;
   int   n_miss = 0;

   logic clk   = 1'b0;
   logic clear = 1'b1;

   always #5 clk = ~clk;

   hazard_ctrl_if hz();

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
      .clk   (clk),
      .clear (clear),
      .hz    (hz)
   );

   task automatic idle();
      hz.rs1_d = 5'd0; hz.rs2_d = 5'd0; hz.rs1_e = 5'd0; hz.rs2_e = 5'd0;
      hz.rd_e = 5'd0; hz.result_src_e = 2'b00; hz.pc_src_e = 1'b0;
      hz.rd_m = 5'd0; hz.rd_w = 5'd0; hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
      hz.dmem_req_m = 1'b0; hz.dmem_ready_m = 1'b0;
   endtask

   function automatic exp_t mk(logic [3:0] st, logic [2:0] fl, logic [1:0] fa,
                               logic [1:0] fb, logic tmo);
      exp_t e;
      e = '0;
      e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb; e.tmo = tmo;
      return e;
   endfunction

   task automatic step(exp_t e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic step_c(exp_t e, int ld, int fl, int mw);
      e.chk_cnt = 1'b1;
      e.c_ld = PERF ? 32'(ld) : 32'd0;
      e.c_fl = PERF ? 32'(fl) : 32'd0;
      e.c_mw = PERF ? 32'(mw) : 32'd0;
      step(e);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      if (act !== req) begin
         n_miss++;
         $display("FAIL vec%0d %s: got %0h, expected %0h", n_vec, name, act, req);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation, mid-cycle
   always @(negedge clk) begin
      if (q.size() != 0) begin
         cur = q.pop_front();
         n_vec++;
         chk("stall", 32'({hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m}), 32'(cur.stall));
         chk("flush", 32'({hz.flush_d, hz.flush_e, hz.flush_w}), 32'(cur.flush));
         chk("fwd_a", 32'(hz.forward_a_e), 32'(cur.fa));
         chk("fwd_b", 32'(hz.forward_b_e), 32'(cur.fb));
         chk("mem_timeout", 32'(hz.mem_timeout), 32'(cur.tmo));
         if (cur.chk_cnt) begin
            chk("ldstall_cnt", hz.ldstall_cnt, cur.c_ld);
            chk("flush_cnt", hz.flush_cnt, cur.c_fl);
            chk("memwait_cnt", hz.memwait_cnt, cur.c_mw);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      clear = 1'b1;
      @(posedge clk); #1;

      // Reset overrides forwarding and hazard inputs
      hz.regwrite_m = 1'b1; hz.rd_m = 5'd5; hz.rs1_e = 5'd5;
      hz.dmem_req_m = 1'b1; hz.pc_src_e = 1'b1;
      step_c(mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0), 0, 0, 0);
      clear = 1'b0;

      // Forwarding: M over W, W alone, x0 never forwarded, independent B select
      idle(); hz.rs1_e = 5'd5; hz.regwrite_m = 1'b1; hz.rd_m = 5'd5;
      hz.regwrite_w = 1'b1; hz.rd_w = 5'd5;
      step(mk(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0));
      hz.regwrite_m = 1'b0;
      step(mk(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0));
      hz.regwrite_m = 1'b1; hz.rd_m = 5'd0; hz.rd_w = 5'd0;
      step(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      idle(); hz.rs1_e = 5'd4; hz.rs2_e = 5'd9; hz.regwrite_m = 1'b1; hz.rd_m = 5'd9;
      hz.regwrite_w = 1'b1; hz.rd_w = 5'd4;
      step(mk(4'b0000, 3'b000, 2'b01, 2'b10, 1'b0));

      // Load-use: one-cycle stall then bubble
      idle(); hz.result_src_e = 2'b01; hz.rd_e = 5'd7; hz.rs2_d = 5'd7;
      step_c(mk(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0), 0, 0, 0);
      idle();
      step_c(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0), 1, 0, 0);

      // Branch together with load-use: flush only
      idle(); hz.result_src_e = 2'b01; hz.rd_e = 5'd7; hz.rs2_d = 5'd7; hz.pc_src_e = 1'b1;
      step(mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
      idle();
      step_c(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0), 1, 1, 0);

      // Three wait cycles then ready
      for (int i = 0; i < 3; i++) begin
         idle(); hz.dmem_req_m = 1'b1;
         step(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
      end
      hz.dmem_ready_m = 1'b1;
      step(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      idle();
      step_c(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0), 1, 1, 3);

      // Zero-wait access
      hz.dmem_req_m = 1'b1; hz.dmem_ready_m = 1'b1;
      step(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      idle();
      step_c(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0), 1, 1, 3);

      // Redirect deferred across a two-cycle wait
      for (int i = 0; i < 2; i++) begin
         idle(); hz.dmem_req_m = 1'b1; hz.pc_src_e = 1'b1;
         step(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
      end
      hz.dmem_ready_m = 1'b1;
      step(mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
      idle();
      step_c(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0), 1, 2, 5);

      // Watchdog: timeout flag set after the fifth edge
      for (int i = 0; i < 5; i++) begin
         idle(); hz.dmem_req_m = 1'b1;
         step(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
      end
      hz.dmem_ready_m = 1'b1;
      step(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1));
      idle(); hz.pc_src_e = 1'b1; hz.result_src_e = 2'b01; hz.rd_e = 5'd7; hz.rs1_d = 5'd7;
      hz.regwrite_m = 1'b1; hz.rd_m = 5'd3; hz.rs2_e = 5'd3;
      step_c(mk(4'b1111, 3'b001, 2'b00, 2'b10, 1'b1), 1, 2, 11);

      // Asynchronous clear mid-cycle leaves TIMEOUT
      clear = 1'b1;
      step_c(mk(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0), 0, 0, 0);
      clear = 1'b0;
      idle();
      step(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      hz.dmem_req_m = 1'b1;
      step(mk(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
      hz.dmem_ready_m = 1'b1;
      step(mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
      idle();

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core; drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, including the D/E control pipeline register.
- Generates E-stage operand forwarding selects.
- Holds the pipeline on data-memory wait states, with a watchdog.
- Sits beside the datapath and takes register indices and control bits from the D, E, M and W stages.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive wait cycles on a data-memory access before the block declares a timeout.
- CNT_W, 7: width of the wait-cycle counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  clock, rising edge.
- Clear  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d  in  5 each  source registers of the instruction in D.
- rs1_e, rs2_e, rd_e  in  5 each  source and destination registers in E.
- result_src_e  in  2  result select in E; value 2'b01 means load.
- pc_src_e  in  1  taken branch, jal or jalr resolved in E.
- rd_m, rd_w  in  5 each  destination registers in M and W.
- regwrite_m, regwrite_w  in  1 each  register write enables in M and W.
- dmem_req_m  in  1  M stage is accessing data memory.
- dmem_ready_m  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC and the D/E/M pipeline registers.
- flush_d, flush_e, flush_w  out  1 each  load a bubble into the D, E and W pipeline registers.
- forward_a_e, forward_b_e  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result.
- mem_timeout  out  1  sticky watchdog error.
- ldstall_cnt, flush_cnt, memwait_cnt  out  32 each  performance counters (see Optional Feature).

Behaviour:
- FSM states: RUN (00), MEM_WAIT (01), TIMEOUT (10). The state register, wait_cnt and mem_timeout are the only sequential elements apart from the optional counters.
- Reset: while Clear is high, state=RUN, wait_cnt=0 and mem_timeout=0.
  - All stall outputs are 0, flush_d=flush_e=1 and flush_w=0.
  - Forwarding selects are 00 and counters are 0.
  - Clear asserted mid-wait returns the block to RUN immediately.
- Forwarding (combinational, every state):
  - Select 10 when regwrite_m && rd_m!=0 && rd_m==rs1_e (or rs2_e).
  - Otherwise select 01 when the same test holds for W.
  - Otherwise select 00. M has priority over W.
- mwait = dmem_req_m && !dmem_ready_m.
- Priority of hazard conditions: mwait, then redirect, then load-use.
- mwait, in RUN or MEM_WAIT:
  - stall_f=stall_d=stall_e=stall_m=1 and flush_w=1; all other flushes are 0.
  - In E, pc_src_e is frozen, so the redirect is deferred until mwait deasserts.
- Redirect, when !mwait && pc_src_e: flush_d=1 and flush_e=1, with no stalls.
  - This also covers a simultaneous load-use hazard: the instruction in D is wrong-path, so no stall is applied.
- Load-use, when !mwait && !pc_src_e && result_src_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d):
  - stall_f=stall_d=1 and flush_e=1, for exactly one cycle.
  - On the next cycle the load is in M and the operand is forwarded from W.
- RUN transitions: goes to MEM_WAIT when mwait; wait_cnt becomes 1.
- MEM_WAIT transitions:
  - mwait: wait_cnt increments.
  - dmem_ready_m=1: stalls release in that same cycle, the block goes to RUN, and wait_cnt becomes 0.
  - wait_cnt==MEM_TIMEOUT with mwait still high: the block goes to TIMEOUT.
- TIMEOUT:
  - mem_timeout=1 and all four stalls are 1, irrespective of inputs.
  - flush_w=1.
  - The only exit is Clear.
- dmem_ready_m arriving together with dmem_req_m in RUN means zero wait cycles: no stall and no state change.
- Outputs other than mem_timeout are combinational from state and inputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three 32-bit counters wrap modulo 2^32 and are cleared by Clear:
  - ldstall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each redirect cycle.
  - memwait_cnt increments on each cycle that stall_m=1.
- When undefined, the counter registers are absent and the three ports are driven constant 0.

Test Plan:
- M/W forwarding: rs1_e=5, regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5 -> forward_a_e=10. Same with regwrite_m=0 -> forward_a_e=01. With rd_m=rd_w=0 -> forward_a_e=00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. ldstall_cnt=1 with HAZARD_PERF_CNT_EN.
- Branch plus load-use: the load-use case above with pc_src_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- Memory wait: dmem_req_m=1, dmem_ready_m=0 for 3 cycles, then 1 -> stalls and flush_w high for 3 cycles, state RUN on the 4th edge, no timeout. memwait_cnt=3.
- Wait with pending redirect: pc_src_e=1 during a 2-cycle wait -> flush_d=flush_e=0 while waiting, then 1 on the first cycle after dmem_ready_m.
- Watchdog and reset: MEM_TIMEOUT=4, dmem_ready_m held 0 -> mem_timeout=1 after the 5th edge, stalls stay 1 with dmem_ready_m=1. Asserting Clear asynchronously -> mem_timeout=0, stalls 0, state RUN.
